micro_pio_ctrl: RTL and testbench
=================================

// Module: micro_pio_ctrl
// PURPOSE
//  Parametrised Avalon-MM parallel I/O port. Generalises the 1-bit output PIO to WIDTH bits.
//  Adds per-bit direction, atomic set/clear, synchronised inputs, edge capture and a maskable IRQ.
//  Sits on the Nios-side system interconnect as an s1 slave; pins go to board-level logic/LEDs/keys.
// PARAMETERS
//  WIDTH      8     number of I/O bits (1..32)
//  RESET_VAL  0     reset value of output data register (WIDTH bits)
//  DIR_RESET  0     reset value of direction register; bit=1 means output
//  EDGE_TYPE  0     capture edge: 0 rising, 1 falling, 2 any
// PORTS
//  clk        in   1      system clock
//  reset_n    in   1      asynchronous reset, active low
//  address    in   3      register select
//  chipselect in   1      slave select
//  write_n    in   1      write strobe, active low
//  writedata  in   32     write data; bits [31:WIDTH] ignored
//  readdata   out  32     read data, zero-extended above WIDTH; zero-wait-state (combinational)
//  pio_in     in   WIDTH  asynchronous external inputs
//  pio_out    out  WIDTH  output data register
//  pio_oe     out  WIDTH  output enable = direction register
//  irq        out  1      interrupt, active high
// BEHAVIOUR
//  Register map (write when chipselect & ~write_n):
//   0 DATA    W: data_out<=wd. R: (dir & data_out) | (~dir & in_s2)
//   1 DIR     R/W direction
//   2 IRQMASK R/W per-bit interrupt enable
//   3 EDGECAP R: captured edges. W: write-1-to-clear
//   4 OUTSET  W: data_out <= data_out | wd. R: 0
//   5 OUTCLR  W: data_out <= data_out & ~wd. R: 0
//   6,7       reserved: writes ignored, read 0
//  Reset (async): data_out=RESET_VAL, dir=DIR_RESET, mask=0, edgecap=0, sync/delay flops=0, irq=0.
//  Input path: pio_in -> in_s1 -> in_s2 (2-flop sync) -> in_d (delay). Edge per bit:
//   rise = in_s2&~in_d; fall = ~in_s2&in_d; any = in_s2^in_d, selected by EDGE_TYPE.
//  Latency: pio_in change sampled at edge N -> in_s2 at N+1 -> edgecap set at N+2.
//  Edges are captured on all bits regardless of DIR (direction affects DATA read only).
//  irq = |(edgecap & mask), combinational from regs; asserts after edge N+2 if unmasked.
//  edgecap bit is sticky until W1C. Same-cycle W1C and new edge on the same bit: edge wins, bit stays 1.
//  Writing 0 to an EDGECAP bit has no effect. Mask change takes effect on irq immediately.
//  Output writes visible on pio_out the cycle after the write edge; no read side effects.
//  chipselect low: no register changes; readdata still reflects address (reads are side-effect free).
//  Reset asserted mid-operation: all state returns to reset values at once; pending edges lost.
//  Pulse on pio_in shorter than one clk period may be missed; this is permitted.
// TESTING
//  T1 reset: pio_out=RESET_VAL, pio_oe=DIR_RESET, irq=0; read addr3 -> 0.
//  T2 WIDTH=8: write DIR=0xFF, DATA=0xA5 -> pio_out=0xA5; OUTSET 0x0A -> 0xAF; OUTCLR 0x81 -> 0x2E; read 0 -> 0x2E.
//  T3 DIR=0x0F, pio_out=0x0C, pio_in=0x30 held 3 clks -> read 0 = 0x3C; write 0xFFFF_FF00 to DATA -> pio_out=0x00.
//  T4 EDGE_TYPE=0, mask=0x01: pio_in[0] 0->1 sampled edge N -> edgecap=0x01 and irq=1 at N+2; 1->0 adds nothing.
//  T5 W1C 0x01 same cycle as new rising edge on bit0 -> edgecap stays 0x01, irq stays 1; next W1C clears, irq=0.
//  T6 edgecap=0x03, mask=0x03, reset_n pulsed low mid-cycle -> edgecap=0, irq=0 immediately (async).

Source files
------------

// File: rtl/micro_pio_ctrl_if.sv
// Avalon-MM s1 slave bus bundle for micro_pio_ctrl: 3-bit register select,
// active-low write strobe, 32-bit data paths with combinational readdata.
interface micro_pio_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/micro_pio_ctrl.sv
// WIDTH-bit parallel I/O port: per-bit direction, atomic set/clear, two-flop
// synchronised inputs, sticky edge capture with write-1-to-clear and maskable IRQ.
module micro_pio_ctrl #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] DIR_RESET = '0,
  parameter int               EDGE_TYPE = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  micro_pio_ctrl_if.slave   bus,
  input  logic [WIDTH-1:0]  pio_in,
  output logic [WIDTH-1:0]  pio_out,
  output logic [WIDTH-1:0]  pio_oe,
  output logic              irq
);

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] in_s1_q, in_s1_d;
  logic [WIDTH-1:0] in_s2_q, in_s2_d;
  logic [WIDTH-1:0] in_d_q, in_d_d;

  logic             wr_en;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] edge_det;
  logic [31:0]      read_word;
  logic             unused_wd;

  assign wr_en     = bus.chipselect & ~bus.write_n;
  assign wd        = bus.writedata[WIDTH-1:0];
  assign unused_wd = ^bus.writedata;

  always_comb begin
    edge_det = '0;
    case (EDGE_TYPE)
      0:       edge_det = in_s2_q & ~in_d_q;
      1:       edge_det = ~in_s2_q & in_d_q;
      default: edge_det = in_s2_q ^ in_d_q;
    endcase
  end

  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    mask_d     = mask_q;
    cap_clr    = '0;
    in_s1_d    = pio_in;
    in_s2_d    = in_s1_q;
    in_d_d     = in_s2_q;
    if (wr_en) begin
      case (bus.address)
        ADDR_DATA:    data_out_d = wd;
        ADDR_DIR:     dir_d      = wd;
        ADDR_IRQMASK: mask_d     = wd;
        ADDR_EDGECAP: cap_clr    = wd;
        ADDR_OUTSET:  data_out_d = data_out_q | wd;
        ADDR_OUTCLR:  data_out_d = data_out_q & ~wd;
        default:      ;
      endcase
    end
    // A fresh edge outranks a same-cycle clear of that bit.
    edgecap_d = (edgecap_q & ~cap_clr) | edge_det;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q <= RESET_VAL;
      dir_q      <= DIR_RESET;
      mask_q     <= '0;
      edgecap_q  <= '0;
      in_s1_q    <= '0;
      in_s2_q    <= '0;
      in_d_q     <= '0;
    end else begin
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      mask_q     <= mask_d;
      edgecap_q  <= edgecap_d;
      in_s1_q    <= in_s1_d;
      in_s2_q    <= in_s2_d;
      in_d_q     <= in_d_d;
    end
  end

  // Reads ignore chipselect so readdata always tracks the selected register.
  always_comb begin
    read_word = '0;
    case (bus.address)
      ADDR_DATA:    read_word[WIDTH-1:0] = (dir_q & data_out_q) | (~dir_q & in_s2_q);
      ADDR_DIR:     read_word[WIDTH-1:0] = dir_q;
      ADDR_IRQMASK: read_word[WIDTH-1:0] = mask_q;
      ADDR_EDGECAP: read_word[WIDTH-1:0] = edgecap_q;
      default:      read_word = '0;
    endcase
  end

  assign bus.readdata = read_word;
  assign pio_out      = data_out_q;
  assign pio_oe       = dir_q;
  assign irq          = |(edgecap_q & mask_q);

endmodule

// File: tb/tb_micro_pio_ctrl.sv
// Scoreboard bench for micro_pio_ctrl: stimulus queues expected values, a
// negedge monitor drains the queue and compares against the live DUT outputs.
module tb_micro_pio_ctrl;

  localparam int          K_READ = 0;
  localparam int          K_OUT  = 1;
  localparam int          K_OE   = 2;
  localparam int          K_IRQ  = 3;
  localparam logic [7:0]  RST_VAL = 8'h5A;
  localparam logic [7:0]  DIR_RST = 8'h0F;

  logic       clk;
  logic       reset_n;
  logic [7:0] pio_in;
  logic [7:0] pio_out;
  logic [7:0] pio_oe;
  logic       irq;

  micro_pio_ctrl_if bus_if ();

  micro_pio_ctrl #(
    .WIDTH     (8),
    .RESET_VAL (RST_VAL),
    .DIR_RESET (DIR_RST),
    .EDGE_TYPE (0)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if),
    .pio_in  (pio_in),
    .pio_out (pio_out),
    .pio_oe  (pio_oe),
    .irq     (irq)
  );

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus moves only just after posedge, so the negedge sees settled outputs.
  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [31:0] act;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.kind)
        K_READ:  act = bus_if.readdata;
        K_OUT:   act = {24'h0, pio_out};
        K_OE:    act = {24'h0, pio_oe};
        default: act = {31'h0, irq};
      endcase
      n_cmp++;
      if (act !== e.exp) begin
        n_fail++;
        $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
      end
    end
  end

  task automatic checkOutput(input int kind, input logic [31:0] exp, input string name);
    exp_t e;
    e.kind = kind;
    e.exp  = exp;
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic cs, input logic [2:0] addr, input logic [31:0] data);
    bus_if.chipselect = cs;
    bus_if.write_n    = 1'b0;
    bus_if.address    = addr;
    bus_if.writedata  = data;
    @(posedge clk); #1;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
  endtask

  task automatic readCheck(input logic [2:0] addr, input logic [31:0] exp, input string name);
    bus_if.address    = addr;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b1;
    checkOutput(K_READ, exp, name);
    @(posedge clk); #1;
    bus_if.chipselect = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n           = 1'b0;
    pio_in            = 8'h00;
    bus_if.address    = 3'd0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = 32'h0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] reset state");
    checkOutput(K_OUT, {24'h0, RST_VAL}, "rst_pio_out");
    checkOutput(K_OE,  {24'h0, DIR_RST}, "rst_pio_oe");
    checkOutput(K_IRQ, 32'h0, "rst_irq");
    readCheck(3'd3, 32'h0,  "rst_edgecap");
    readCheck(3'd2, 32'h0,  "rst_mask");
    readCheck(3'd1, 32'h0F, "rst_dir");
    readCheck(3'd0, 32'h0A, "rst_data_mix");

    $display("[TB] output data, set and clear");
    applyStimulus(1'b1, 3'd1, 32'hFF);
    checkOutput(K_OE, 32'hFF, "dir_ff");
    applyStimulus(1'b1, 3'd0, 32'hA5);
    checkOutput(K_OUT, 32'hA5, "data_a5");
    applyStimulus(1'b1, 3'd4, 32'h0A);
    checkOutput(K_OUT, 32'hAF, "outset_0a");
    applyStimulus(1'b1, 3'd5, 32'h81);
    checkOutput(K_OUT, 32'h2E, "outclr_81");
    readCheck(3'd0, 32'h2E, "read_data_2e");
    readCheck(3'd4, 32'h0,  "read_outset_zero");
    readCheck(3'd5, 32'h0,  "read_outclr_zero");
    applyStimulus(1'b1, 3'd6, 32'hFF);
    checkOutput(K_OUT, 32'h2E, "reserved_write_ignored");
    readCheck(3'd6, 32'h0,  "read_reserved_zero");
    applyStimulus(1'b0, 3'd0, 32'h00);
    checkOutput(K_OUT, 32'h2E, "cs_low_write_ignored");

    $display("[TB] mixed direction and input sync");
    applyStimulus(1'b1, 3'd1, 32'h0F);
    applyStimulus(1'b1, 3'd0, 32'h0C);
    checkOutput(K_OUT, 32'h0C, "data_0c");
    pio_in = 8'h30;
    idle(3);
    readCheck(3'd0, 32'h3C, "read_data_mixed_3c");
    applyStimulus(1'b1, 3'd0, 32'hFFFF_FF00);
    checkOutput(K_OUT, 32'h00, "upper_bits_ignored");
    checkOutput(K_IRQ, 32'h0, "masked_irq_low");
    readCheck(3'd3, 32'h30, "edgecap_input_bits");
    applyStimulus(1'b1, 3'd3, 32'h00);
    readCheck(3'd3, 32'h30, "w0_edgecap_no_effect");
    applyStimulus(1'b1, 3'd2, 32'h10);
    checkOutput(K_IRQ, 32'h1, "mask_on_irq_immediate");
    applyStimulus(1'b1, 3'd2, 32'h00);
    checkOutput(K_IRQ, 32'h0, "mask_off_irq_immediate");
    applyStimulus(1'b1, 3'd3, 32'h30);
    readCheck(3'd3, 32'h00, "w1c_clears");

    $display("[TB] rising edge latency");
    applyStimulus(1'b1, 3'd2, 32'h01);
    pio_in = 8'h31;
    idle(1);
    checkOutput(K_IRQ, 32'h0, "irq_low_at_n");
    idle(1);
    checkOutput(K_IRQ, 32'h0, "irq_low_at_n1");
    idle(1);
    checkOutput(K_IRQ, 32'h1, "irq_high_at_n2");
    readCheck(3'd3, 32'h01, "edgecap_bit0");
    pio_in = 8'h30;
    idle(4);
    readCheck(3'd3, 32'h01, "falling_not_captured");

    $display("[TB] clear collides with new edge");
    applyStimulus(1'b1, 3'd3, 32'h01);
    readCheck(3'd3, 32'h00, "w1c_bit0");
    pio_in = 8'h31;
    idle(2);
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    bus_if.address    = 3'd3;
    bus_if.writedata  = 32'h01;
    @(posedge clk); #1;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    checkOutput(K_IRQ, 32'h1, "edge_wins_irq");
    readCheck(3'd3, 32'h01, "edge_wins_edgecap");
    applyStimulus(1'b1, 3'd3, 32'h01);
    checkOutput(K_IRQ, 32'h0, "second_w1c_irq");
    readCheck(3'd3, 32'h00, "second_w1c_edgecap");

    $display("[TB] async reset mid-operation");
    pio_in = 8'h30;
    idle(3);
    pio_in = 8'h33;
    idle(3);
    applyStimulus(1'b1, 3'd2, 32'h03);
    checkOutput(K_IRQ, 32'h1, "pre_reset_irq");
    readCheck(3'd3, 32'h03, "pre_reset_edgecap");
    #1 reset_n = 1'b0;
    bus_if.address = 3'd3;
    checkOutput(K_READ, 32'h0, "async_rst_edgecap");
    checkOutput(K_IRQ,  32'h0, "async_rst_irq");
    checkOutput(K_OUT,  {24'h0, RST_VAL}, "async_rst_pio_out");
    checkOutput(K_OE,   {24'h0, DIR_RST}, "async_rst_pio_oe");
    @(negedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    idle(3);
    checkOutput(K_IRQ, 32'h0, "post_rst_irq_masked");
    readCheck(3'd2, 32'h0, "post_rst_mask");

    idle(2);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
